ex_branch_stage: RTL and testbench

//  Execute-stage back end of the RV32I core, directly downstream of alu. Consumes alu.result and
//  alu N/Z/C/V flags plus decoded control, resolves branches/jumps under static not-taken prediction,
//  and registers the EX/MEM pipeline slot with valid/ready handshake, redirect and wrong-path squash.

---
 rtl/ex_branch_stage_pkg.sv | 40 ++++
 rtl/ex_branch_stage_br_cond.sv | 34 +++
 rtl/ex_branch_stage.sv | 170 +++++++++++++++++
 tb/tb_ex_branch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_branch_stage_pkg.sv
// ============================================================================
// ex_branch_stage_pkg : shared encodings for the EX branch/commit stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package ex_branch_stage_pkg;

  localparam int XLEN_DEF = 32;

  // Instruction class driving the stage
  localparam logic [1:0] KIND_ALU    = 2'b00;
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_JAL    = 2'b10;
  localparam logic [1:0] KIND_JALR   = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Upstream alu opcodes; branches are resolved from the flags of ALU_SUB
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  function automatic logic is_jump(input logic [1:0] kind);
    return (kind == KIND_JAL) || (kind == KIND_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_branch_stage_br_cond.sv
// ============================================================================
// ex_branch_stage_br_cond : RV32I branch condition from funct3 and SUB flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_branch_stage_br_cond
  import ex_branch_stage_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_c,
  input  logic       i_v,
  output logic       o_taken
);

  // C=1 means a>=b unsigned; funct3 010/011 are not branches and fall to not-taken
  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_z;
      F3_BNE:  o_taken = ~i_z;
      F3_BLT:  o_taken = i_n ^ i_v;
      F3_BGE:  o_taken = ~(i_n ^ i_v);
      F3_BLTU: o_taken = ~i_c;
      F3_BGEU: o_taken = i_c;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_branch_stage.sv
// ============================================================================
// ex_branch_stage : branch resolution, redirect/squash and EX/MEM slot
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_branch_stage
  import ex_branch_stage_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_rd,
  input  logic             in_mem_wr,
  input  logic [XLEN-1:0]  in_store_data,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic [XLEN-1:0]  out_store_data,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_redirect
);

  localparam logic [1:0] SQ_LAST = 2'(SQUASH_CYCLES - 1);

  logic [0:0]      r_state;
  logic [1:0]      r_sq_cnt;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_result;
  logic [4:0]      r_out_rd;
  logic            r_out_reg_write;
  logic            r_out_mem_rd;
  logic            r_out_mem_wr;
  logic [XLEN-1:0] r_out_store_data;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;
  logic [CNT_W-1:0] r_cnt_branch;
  logic [CNT_W-1:0] r_cnt_redirect;

  logic            w_cond;
  logic            w_is_branch;
  logic            w_is_jump;
  logic            w_taken;
  logic            w_accept;
  logic            w_live;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_link;

  ex_branch_stage_br_cond u_br_cond (
    .i_funct3 (in_funct3),
    .i_n      (alu_n),
    .i_z      (alu_z),
    .i_c      (alu_c),
    .i_v      (alu_v),
    .o_taken  (w_cond)
  );

  assign w_is_branch = (in_kind == KIND_BRANCH);
  assign w_is_jump   = is_jump(in_kind);
  assign w_taken     = w_is_jump | (w_is_branch & w_cond);
  assign w_link      = in_pc + XLEN'(4);
  assign w_target    = (in_kind == KIND_JALR) ? {alu_result[XLEN-1:1], 1'b0}
                                              : in_pc + in_imm;

  // While squashing, wrong-path inputs are swallowed regardless of the slot
  assign in_ready = (r_state == ST_SQUASH) | ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_live   = w_accept & (r_state == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid      <= 1'b0;
      r_out_result     <= '0;
      r_out_rd         <= '0;
      r_out_reg_write  <= 1'b0;
      r_out_mem_rd     <= 1'b0;
      r_out_mem_wr     <= 1'b0;
      r_out_store_data <= '0;
    end else if (w_live) begin
      r_out_valid      <= 1'b1;
      r_out_result     <= w_is_jump ? w_link : alu_result;
      r_out_rd         <= in_rd;
      r_out_reg_write  <= in_reg_write & ~w_is_branch;
      r_out_mem_rd     <= in_mem_rd;
      r_out_mem_wr     <= in_mem_wr;
      r_out_store_data <= in_store_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
      r_cnt_branch   <= '0;
      r_cnt_redirect <= '0;
    end else begin
      r_redirect <= w_live & w_taken;
      if (w_live & w_taken) begin
        r_redirect_pc  <= w_target;
        r_cnt_redirect <= r_cnt_redirect + CNT_W'(1);
      end
      if (w_live & w_is_branch) begin
        r_cnt_branch <= r_cnt_branch + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_live & w_taken) begin
            r_state  <= ST_SQUASH;
            r_sq_cnt <= SQ_LAST;
          end
        end
        ST_SQUASH: begin
          if (r_sq_cnt == 2'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_sq_cnt <= r_sq_cnt - 2'd1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_rd         = r_out_rd;
  assign out_reg_write  = r_out_reg_write;
  assign out_mem_rd     = r_out_mem_rd;
  assign out_mem_wr     = r_out_mem_wr;
  assign out_store_data = r_out_store_data;
  assign redirect       = r_redirect;
  assign redirect_pc    = r_redirect_pc;
  assign cnt_branch     = r_cnt_branch;
  assign cnt_redirect   = r_cnt_redirect;

endmodule

`default_nettype wire

// File: tb/tb_ex_branch_stage.sv
// ============================================================================
// tb_ex_branch_stage : scoreboard bench for ex_branch_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_branch_stage;
  import ex_branch_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  in_pc, in_imm, in_store_data, alu_result;
  logic [1:0]       in_kind;
  logic [2:0]       in_funct3;
  logic [4:0]       in_rd;
  logic             in_reg_write, in_mem_rd, in_mem_wr;
  logic             alu_n, alu_z, alu_c, alu_v;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_result, out_store_data, redirect_pc;
  logic [4:0]       out_rd;
  logic             out_reg_write, out_mem_rd, out_mem_wr, redirect;
  logic [CNT_W-1:0] cnt_branch, cnt_redirect;

  always #5 clk = ~clk;

  ex_branch_stage #(.XLEN(XLEN), .SQUASH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_kind(in_kind), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_rd(in_mem_rd),
    .in_mem_wr(in_mem_wr), .in_store_data(in_store_data),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .cnt_branch(cnt_branch), .cnt_redirect(cnt_redirect)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mrd;
    logic        mwr;
    logic [31:0] sd;
  } out_t;

  out_t        exp_q[$];
  logic [31:0] redir_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                            input logic mrd, input logic mwr, input logic [31:0] sd);
    out_t o;
    o.result = res; o.rd = rd; o.rw = rw; o.mrd = mrd; o.mwr = mwr; o.sd = sd;
    exp_q.push_back(o);
  endtask

  // Slot transfers and redirect pulses are checked as they appear
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got result %h expected no output", out_result);
      end else begin
        out_t e;
        e = exp_q.pop_front();
        chk("out_result", out_result, e.result);
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_flags", {29'b0, out_reg_write, out_mem_rd, out_mem_wr}, {29'b0, e.rw, e.mrd, e.mwr});
        chk("out_store_data", out_store_data, e.sd);
      end
    end
    if (!reset && redirect) begin
      checks++;
      if (redir_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
      end else begin
        logic [31:0] rp;
        rp = redir_q.pop_front();
        chk("redirect_pc", redirect_pc, rp);
      end
    end
  end

  task automatic set_ins(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                         input logic mrd, input logic mwr, input logic [31:0] sd,
                         input logic [31:0] alu, input logic [3:0] nzcv);
    in_kind = k; in_funct3 = f3; in_pc = pc; in_imm = imm; in_rd = rd;
    in_reg_write = rw; in_mem_rd = mrd; in_mem_wr = mwr; in_store_data = sd;
    alu_result = alu; {alu_n, alu_z, alu_c, alu_v} = nzcv;
  endtask

  task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                       input logic mrd, input logic mwr, input logic [31:0] sd,
                       input logic [31:0] alu, input logic [3:0] nzcv);
    int n;
    set_ins(k, f3, pc, imm, rd, rw, mrd, mwr, sd, alu, nzcv);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jal_taken(input logic [31:0] pc, input logic [31:0] imm);
    expect_out(pc + 32'd4, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    redir_q.push_back(pc + imm);
    issue(KIND_JAL, 3'b000, pc, imm, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_ins(KIND_ALU, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_cnt_branch", 32'(cnt_branch), 32'h0);
    chk("rst_cnt_redirect", 32'(cnt_redirect), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // BEQ taken, then two wrong-path inputs swallowed, third is live
    expect_out(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    redir_q.push_back(32'h120);
    issue(KIND_BRANCH, F3_BEQ, 32'h100, 32'h20, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100);
    issue(KIND_ALU, 3'b000, 32'h104, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h11, 4'b0000);
    issue(KIND_ALU, 3'b000, 32'h108, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h22, 4'b0000);
    expect_out(32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(KIND_ALU, 3'b000, 32'h120, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h33, 4'b0000);
    idle(2);
    chk("cnt_branch_beq", 32'(cnt_branch), 32'd1);
    chk("cnt_redirect_beq", 32'(cnt_redirect), 32'd1);

    // BLT -1<1 taken; BLTU 0xFFFFFFFF<1 not taken; funct3 010 not taken
    expect_out(32'hFFFFFFFE, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0);
    redir_q.push_back(32'h210);
    issue(KIND_BRANCH, F3_BLT, 32'h200, 32'h10, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFE, 4'b1010);
    idle(3);
    expect_out(32'hFFFFFFFE, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0);
    issue(KIND_BRANCH, F3_BLTU, 32'h300, 32'h10, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFE, 4'b1010);
    expect_out(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    issue(KIND_BRANCH, 3'b010, 32'h304, 32'h10, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    idle(2);
    chk("cnt_branch_blt", 32'(cnt_branch), 32'd4);
    chk("cnt_redirect_blt", 32'(cnt_redirect), 32'd2);

    // JALR clears target bit 0 and links pc+4
    expect_out(32'h44, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    redir_q.push_back(32'h2002);
    issue(KIND_JALR, 3'b000, 32'h40, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2003, 4'b0000);
    idle(3);
    chk("cnt_redirect_jalr", 32'(cnt_redirect), 32'd3);

    // Backpressure: full slot holds, no accept for 3 cycles, then drains
    out_ready = 1'b0;
    expect_out(32'h1000, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    issue(KIND_ALU, 3'b000, 32'h500, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h1000, 4'b0000);
    set_ins(KIND_ALU, 3'b000, 32'h504, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0, 32'h2000, 4'b0000);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_result", out_result, 32'h1000);
      chk("bp_store_data", out_store_data, 32'hDEADBEEF);
    end
    expect_out(32'h2000, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // JAL across the top of the address space, then redirect counter wrap
    jal_taken(32'hFFFFFFFC, 32'h8);
    chk("cnt_redirect_jal", 32'(cnt_redirect), 32'd4);
    for (int i = 0; i < 11; i++) begin
      jal_taken(32'h1000 + 32'(i) * 32'h10, 32'h100);
    end
    chk("cnt_redirect_max", 32'(cnt_redirect), 32'hF);
    jal_taken(32'h3000, 32'h40);
    chk("cnt_redirect_wrap", 32'(cnt_redirect), 32'h0);
    chk("cnt_branch_final", 32'(cnt_branch), 32'd4);

    // Reset while squashing with a stalled full slot
    out_ready = 1'b0;
    set_ins(KIND_JAL, 3'b000, 32'h600, 32'h40, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sq_out_valid", 32'(out_valid), 32'h1);
    chk("sq_redirect", 32'(redirect), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_redirect", 32'(redirect), 32'h0);
    chk("mid_rst_redirect_pc", redirect_pc, 32'h0);
    chk("mid_rst_cnt_branch", 32'(cnt_branch), 32'h0);
    @(negedge clk) reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    expect_out(32'h77, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(KIND_ALU, 3'b000, 32'h700, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0, 32'h77, 4'b0000);
    idle(3);

    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("redir_q_empty", 32'(redir_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
